// File: rtl/ddr_app_responder.sv
// ddr_app_responder
//   Stand-in for the MIG user (app_*) interface. It accepts write commands and
//   write data into two small FIFOs and pairs them up to commit words into an
//   on-chip array. Reads return array data after a fixed latency. Calibration
//   delay and backpressure are emulated so that the DDR controller above it
//   sees realistic handshakes.
//
//   Optional feature macro: DDR_RESP_BACKPRESSURE_EN
//     When it is defined, a 16-bit LFSR randomly deasserts app_rdy and
//     app_wdf_rdy once calibration is done.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   app_addr/cmd/en/rdy    command channel (000 write, 001 read, others flagged)
//   app_wdf_*              write-data channel (single-beat words, mask 1 = keep)
//   app_rd_data(_valid)    read return, in order, no backpressure
//   init_calib_complete    high CALIB_CYCLES edges after reset release
//   proto_err              sticky protocol-violation flag
module ddr_app_responder #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int MEM_AW         = 10,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 16,
  parameter int FIFO_AW        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DDR_ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]                  app_cmd,
  input  logic                        app_en,
  output logic                        app_rdy,
  input  logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                        app_wdf_wren,
  input  logic                        app_wdf_end,
  output logic                        app_wdf_rdy,
  output logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
  output logic                        app_rd_data_valid,
  output logic                        init_calib_complete,
  output logic                        proto_err
);

  localparam int DW = DDR_DATA_WIDTH;
  localparam int NB = DDR_DATA_WIDTH / 8;
  localparam int FD = 1 << FIFO_AW;
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // calibration timer: down-counter, done on the edge where it sits at zero
  logic          calib;
  logic [CW-1:0] calib_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calib_cnt <= CW'(CALIB_CYCLES - 1);
      calib     <= 1'b0;
    end else if (!calib) begin
      if (calib_cnt == '0) calib <= 1'b1;
      else                 calib_cnt <= calib_cnt - 1'b1;
    end
  end

  assign init_calib_complete = calib;

  logic bp_cmd, bp_wdf;

`ifdef DDR_RESP_BACKPRESSURE_EN
  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, frozen until calibrated
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        lfsr <= 16'hACE1;
    else if (calib) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign bp_cmd = (lfsr[1:0] == 2'b00);
  assign bp_wdf = (lfsr[3:2] == 2'b00);
`else
  assign bp_cmd = 1'b0;
  assign bp_wdf = 1'b0;
`endif

  // write-command FIFO (word index) and write-data FIFO ({data, mask})
  logic [FIFO_AW:0]   wc_wp, wc_rp, wd_wp, wd_rp;
  logic [MEM_AW-1:0]  wc_mem [FD];
  logic [DW+NB-1:0]   wd_mem [FD];
  logic               wc_empty, wc_full, wd_empty, wd_full;

  assign wc_empty = (wc_wp == wc_rp);
  assign wd_empty = (wd_wp == wd_rp);
  assign wc_full  = (wc_wp[FIFO_AW] != wc_rp[FIFO_AW]) &&
                    (wc_wp[FIFO_AW-1:0] == wc_rp[FIFO_AW-1:0]);
  assign wd_full  = (wd_wp[FIFO_AW] != wd_rp[FIFO_AW]) &&
                    (wd_wp[FIFO_AW-1:0] == wd_rp[FIFO_AW-1:0]);

  logic [MEM_AW-1:0] cmd_idx;
  logic              cmd_is_wr, cmd_is_rd, cmd_acc;
  logic              wc_push, wd_push, rd_acc, bad_acc, commit;

  assign cmd_idx   = app_addr[MEM_AW+2:3];
  assign cmd_is_wr = (app_cmd == CMD_WR);
  assign cmd_is_rd = (app_cmd == CMD_RD);

  // a read is held off until all earlier write commands have committed
  assign app_rdy     = calib & ~wc_full & ~(cmd_is_rd & ~wc_empty) & ~bp_cmd;
  assign app_wdf_rdy = calib & ~wd_full & ~bp_wdf;

  assign cmd_acc = app_en & app_rdy;
  assign wc_push = cmd_acc & cmd_is_wr;
  assign rd_acc  = cmd_acc & cmd_is_rd;
  assign bad_acc = cmd_acc & ~cmd_is_wr & ~cmd_is_rd;
  assign wd_push = app_wdf_wren & app_wdf_rdy;
  assign commit  = ~wc_empty & ~wd_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc_wp <= '0;
      wc_rp <= '0;
      wd_wp <= '0;
      wd_rp <= '0;
    end else begin
      if (wc_push) wc_wp <= wc_wp + 1'b1;
      if (wd_push) wd_wp <= wd_wp + 1'b1;
      if (commit) begin
        wc_rp <= wc_rp + 1'b1;
        wd_rp <= wd_rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wc_push) wc_mem[wc_wp[FIFO_AW-1:0]] <= cmd_idx;
    if (wd_push) wd_mem[wd_wp[FIFO_AW-1:0]] <= {app_wdf_data, app_wdf_mask};
  end

  logic [MEM_AW-1:0] cm_idx;
  logic [DW+NB-1:0]  cm_word;

  assign cm_idx  = wc_mem[wc_rp[FIFO_AW-1:0]];
  assign cm_word = wd_mem[wd_rp[FIFO_AW-1:0]];

  // storage array, deliberately not reset so contents survive rst
  logic [DW-1:0] mem [1 << MEM_AW];

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (!cm_word[b]) mem[cm_idx][b*8 +: 8] <= cm_word[NB + b*8 +: 8];
      end
    end
  end

  // read path: stage 0 is the synchronous array read, then RD_LATENCY-1 delays
  logic [RD_LATENCY-1:0] rd_vld;
  logic [DW-1:0]         rd_dat [RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_dat[i] <= '0;
    end else begin
      rd_vld[0] <= rd_acc;
      if (rd_acc) rd_dat[0] <= mem[cmd_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        rd_dat[i] <= rd_dat[i-1];
      end
    end
  end

  assign app_rd_data_valid = rd_vld[RD_LATENCY-1];
  assign app_rd_data       = rd_dat[RD_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err <= 1'b0;
    else if (bad_acc || (app_wdf_wren && !app_wdf_end)) proto_err <= 1'b1;
  end

  // address bits outside the word index are aliased away
  logic unused_addr_bits;
  assign unused_addr_bits = ^{app_addr[DDR_ADDR_WIDTH-1:MEM_AW+3], app_addr[2:0]};

endmodule

// File: tb/tb_ddr_app_responder.sv
// tb_ddr_app_responder
//   Drives the app_* interface from tasks on the falling edge and checks read
//   returns against a scoreboard queue filled at read-accept time from a
//   reference word array.
module tb_ddr_app_responder;

  localparam int DW = 128;
  localparam int AW = 28;
  localparam int RDL = 4;
  localparam int CAL = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   app_addr = '0;
  logic [2:0]      app_cmd = 3'b000;
  logic            app_en = 1'b0;
  logic            app_rdy;
  logic [DW-1:0]   app_wdf_data = '0;
  logic [DW/8-1:0] app_wdf_mask = '0;
  logic            app_wdf_wren = 1'b0;
  logic            app_wdf_end = 1'b0;
  logic            app_wdf_rdy;
  logic [DW-1:0]   app_rd_data;
  logic            app_rd_data_valid;
  logic            init_calib_complete;
  logic            proto_err;

  ddr_app_responder #(
    .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .MEM_AW(10),
    .RD_LATENCY(RDL), .CALIB_CYCLES(CAL), .FIFO_AW(2)
  ) dut (
    .clk(clk), .rst(rst),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .init_calib_complete(init_calib_complete), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] model_mem [1024];
  logic [DW-1:0] exp_q [$];
  int            acc_q [$];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [DW/8-1:0] mask);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < DW/8; b++) if (!mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // read-return monitor
  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("rd_data", app_rd_data, exp_q.pop_front());
        check("rd_latency", cyc - acc_q.pop_front(), RDL);
      end
    end
  end

  task automatic do_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr);
    int n;
    @(negedge clk);
    app_en = 1'b1;
    app_cmd = cmd;
    app_addr = addr;
    n = 0;
    #1;
    while (!app_rdy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!app_rdy) begin
      check("cmd_timeout", 0, 1);
    end else if (cmd == 3'b001) begin
      exp_q.push_back(model_mem[addr[12:3]]);
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    app_en = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d, input logic [DW/8-1:0] m);
    int n;
    @(negedge clk);
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b1;
    app_wdf_data = d;
    app_wdf_mask = m;
    n = 0;
    #1;
    while (!app_wdf_rdy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!app_wdf_rdy) check("wdf_timeout", 0, 1);
    @(posedge clk);
    #1;
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] m);
    model_mem[addr[12:3]] = merge(model_mem[addr[12:3]], d, m);
    do_cmd(3'b000, addr);
    send_data(d, m);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_calib();
    int n;
    n = 0;
    while (!init_calib_complete && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("calib_wait", init_calib_complete, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic [AW-1:0] a5 [5];

    // reset state
    repeat (3) @(negedge clk);
    check("rst_app_rdy", app_rdy, 0);
    check("rst_wdf_rdy", app_wdf_rdy, 0);
    check("rst_valid", app_rd_data_valid, 0);
    check("rst_rd_data", app_rd_data, 0);
    check("rst_calib", init_calib_complete, 0);
    check("rst_proto", proto_err, 0);

    // calibration rises on the 16th edge after release
    rst = 1'b0;
    repeat (CAL - 1) @(negedge clk);
    check("calib_pre", init_calib_complete, 0);
    check("app_rdy_pre", app_rdy, 0);
    check("wdf_rdy_pre", app_wdf_rdy, 0);
    @(negedge clk);
    check("calib_at16", init_calib_complete, 1);
    check("wdf_rdy_post", app_wdf_rdy, 1);

    // full write then read-back
    do_write(28'h40, {16{8'hA5}}, '0);
    do_cmd(3'b001, 28'h40);
    drain();

    // command ahead of its data, partial mask
    do_write(28'h08, {16{8'h11}}, '0);
    model_mem[1] = merge(model_mem[1], 128'h1234, 16'hFFFE);
    do_cmd(3'b000, 28'h08);
    repeat (3) @(negedge clk);
    send_data(128'h1234, 16'hFFFE);
    do_cmd(3'b001, 28'h08);
    drain();
    check("mask_model", model_mem[1], {{15{8'h11}}, 8'h34});

    // five write commands without data: the fifth must stall
    for (int i = 0; i < 5; i++) begin
      a5[i] = 28'h100 + 28'(i * 8);
      d = {$urandom, $urandom, $urandom, 32'(i)};
      model_mem[a5[i][12:3]] = d;
    end
    for (int i = 0; i < 4; i++) do_cmd(3'b000, a5[i]);
    @(negedge clk);
    app_en = 1'b1;
    app_cmd = 3'b000;
    app_addr = a5[4];
    #1;
    check("rdy_after4", app_rdy, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rdy_after4_hold", app_rdy, 0);
    app_en = 1'b0;
    fork
      do_cmd(3'b000, a5[4]);
      for (int i = 0; i < 5; i++) send_data(model_mem[a5[i][12:3]], '0);
    join

    // eight back-to-back reads
    for (int i = 0; i < 5; i++) do_cmd(3'b001, a5[i]);
    do_cmd(3'b001, 28'h40);
    do_cmd(3'b001, 28'h08);
    do_cmd(3'b001, 28'h40 | 28'h8000000);
    drain();

    // bad command sets sticky proto_err
    check("proto_clean", proto_err, 0);
    do_cmd(3'b010, 28'h0);
    @(negedge clk);
    check("proto_set", proto_err, 1);
    repeat (5) @(negedge clk);
    check("proto_sticky", proto_err, 1);

    // reset with reads in flight: nothing comes back, array retained
    do_cmd(3'b001, 28'h40);
    do_cmd(3'b001, 28'h08);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("mid_rst_valid", app_rd_data_valid, 0);
    check("mid_rst_calib", init_calib_complete, 0);
    check("mid_rst_proto", proto_err, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_rdy", app_rdy, 0);
    wait_calib();
    do_cmd(3'b001, 28'h40);
    drain();

`ifdef DDR_RESP_BACKPRESSURE_EN
    for (int i = 0; i < 1023; i++)
      do_write(28'(i * 8), {$urandom, $urandom, $urandom, $urandom}, '0);
    for (int i = 0; i < 1023; i++) do_cmd(3'b001, 28'(i * 8));
    drain();
`endif

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
